// File: rtl/div_unit_pkg.sv
// Shared CPU definitions used by the divider slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_unit_if.sv
// Control-unit <-> divider signal bundle (start, operands, results, status).
// Latency: n/a (wires only).
// Backpressure: none; the control unit waits on DivDone before issuing again.
//   master: control unit side (drives DivControl/DivA/DivB)
//   slave : divider side (drives Hi/Lo/DivBusy/DivDone/DivZero)
interface div_unit_if
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             DivControl;
    logic [WIDTH-1:0] DivA;
    logic [WIDTH-1:0] DivB;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic             DivBusy;
    logic             DivDone;
    logic             DivZero;

    modport master (
        output DivControl, DivA, DivB,
        input  Hi, Lo, DivBusy, DivDone, DivZero
    );

    modport slave (
        input  DivControl, DivA, DivB,
        output Hi, Lo, DivBusy, DivDone, DivZero
    );
endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift {rem, quo} left, trial-subtract divisor.
// Latency: combinational.
// Backpressure: n/a.
//   rem/quo/dmag in -> rem_n/quo_n out (unsigned magnitudes)
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] rem_n,
    output logic [WIDTH-1:0] quo_n
);
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // rem < dmag always holds, so the shifted value needs one extra bit and a
    // successful subtract always fits back into WIDTH bits.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dmag};

    always_comb begin
        rem_n = shifted[WIDTH-1:0];
        quo_n = {quo[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            rem_n = diff[WIDTH-1:0];
            quo_n = {quo[WIDTH-2:0], 1'b1};
        end
    end
endmodule

// File: rtl/div_unit.sv
// Multicycle signed divider (MIPS div): Lo=quotient toward zero, Hi=remainder.
// Latency: WIDTH+2 cycles start->DivDone; 1 cycle for divide-by-zero.
// Backpressure: DivControl ignored unless IDLE; no queueing.
//   Clk, Reset (async active-low), bus (slave): DivControl/DivA/DivB in,
//   Hi/Lo/DivBusy/DivDone/DivZero out, all outputs registered or state-decoded.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic        Clk,
    input  logic        Reset,
    div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    div_state_t state, state_n;

    logic [WIDTH-1:0] rem, quo, dmag;
    logic [WIDTH-1:0] rem_n, quo_n;
    logic [WIDTH-1:0] hi, lo;
    logic [CW-1:0]    cnt;
    logic             sign_a, sign_b, zero;
    logic             start;

    assign start = (state == IDLE) && bus.DivControl;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem   (rem),
        .quo   (quo),
        .dmag  (dmag),
        .rem_n (rem_n),
        .quo_n (quo_n)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (bus.DivControl) state_n = (bus.DivB == '0) ? DONE : CALC;
            CALC: if (cnt == LAST)    state_n = FIX;
            FIX:                      state_n = DONE;
            DONE:                     state_n = IDLE;
            default:                  state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rem    <= '0;
            quo    <= '0;
            dmag   <= '0;
            hi     <= '0;
            lo     <= '0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            zero   <= 1'b0;
        end else begin
            if (start) begin
                if (bus.DivB == '0) begin
                    zero <= 1'b1;
                end else begin
                    // Quotient register starts as |A|; its bits shift into rem.
                    quo    <= bus.DivA[WIDTH-1] ? -bus.DivA : bus.DivA;
                    dmag   <= bus.DivB[WIDTH-1] ? -bus.DivB : bus.DivB;
                    sign_a <= bus.DivA[WIDTH-1];
                    sign_b <= bus.DivB[WIDTH-1];
                    rem    <= '0;
                    cnt    <= '0;
                    zero   <= 1'b0;
                end
            end
            if (state == CALC) begin
                rem <= rem_n;
                quo <= quo_n;
                cnt <= cnt + 1'b1;
            end
            if (state == FIX) begin
                lo <= (sign_a ^ sign_b) ? -quo : quo;
                hi <= sign_a ? -rem : rem;
            end
        end
    end

    assign bus.Hi      = hi;
    assign bus.Lo      = lo;
    assign bus.DivZero = zero;
    assign bus.DivBusy = (state == CALC) || (state == FIX);
    assign bus.DivDone = (state == DONE);
endmodule

// File: doc/div_unit.md
# div_unit

Multicycle signed integer divider for the multicycle MIPS datapath. It sits beside the existing multiplier, downstream of the A/B operand registers. Results go to the Hi/Lo sources for the mfhi/mflo write-back path. The control unit starts it with a one-cycle pulse and waits in a dedicated state until it reports done.

## Interface
- WIDTH, 32, operand and result width in bits
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- DivControl  input  1  start pulse, sampled only in IDLE
- DivA  input  WIDTH  dividend, two's complement (RegA output)
- DivB  input  WIDTH  divisor, two's complement (RegB output)
- Hi  output  WIDTH  remainder, held between operations
- Lo  output  WIDTH  quotient, held between operations
- DivBusy  output  1  high in CALC and FIX
- DivDone  output  1  one-cycle pulse, high in DONE only
- DivZero  output  1  divide-by-zero flag, sticky until the next accepted start

## Operation
- States:
  - IDLE: waits for a start.
  - CALC: performs restoring shift/subtract on the operand magnitudes, one quotient bit per cycle, WIDTH cycles, using a 0..WIDTH-1 step counter.
  - FIX: applies signs and writes Hi and Lo.
  - DONE: raises DivDone, then returns to IDLE.
- IDLE, DivControl=1, DivB≠0:
  - latch |DivA|, |DivB| and both sign bits;
  - clear the partial remainder, the step counter and DivZero;
  - go to CALC.
- IDLE, DivControl=1, DivB=0: set DivZero=1, leave Hi/Lo unchanged, go straight to DONE.
- CALC step: shift {rem, quo} left by 1, trial-subtract the divisor magnitude from rem (WIDTH+1-bit subtract). If non-negative, keep the difference and set quo[0]=1. After step WIDTH-1, go to FIX.
- FIX:
  - Lo = quo, negated if the operand signs differ;
  - Hi = rem, negated if the dividend is negative;
  - i.e. truncation toward zero, remainder takes the sign of the dividend (MIPS div).
- Overflow case: 0x80000000 / 0xFFFFFFFF gives Lo=0x80000000, Hi=0. Result wraps modulo 2^WIDTH; no flag is raised.
- DivControl is ignored in CALC, FIX and DONE. There is no queueing.
- Operand changes after the start edge have no effect, because operands are latched at the start edge.
- Reset asserted at any time, including mid-operation: immediately forces IDLE, Hi=Lo=0, DivBusy=DivDone=DivZero=0, and clears all internal registers.

## Timing
- Start accepted at rising edge k.
- CALC occupies edges k+1 … k+WIDTH, with the last step at edge k+WIDTH.
- FIX is the cycle after edge k+WIDTH. Hi/Lo update at edge k+WIDTH+1.
- DivDone=1 during the cycle after edge k+WIDTH+1, with Hi/Lo already valid. The state returns to IDLE at edge k+WIDTH+2.
- Total: WIDTH+2 cycles from start to DivDone; 34 for WIDTH=32.
- A new start is accepted at earliest at edge k+WIDTH+3.
- Divide by zero: DivDone is high in the cycle after edge k (latency 1). DivZero is high from edge k until the next accepted start.
- Outputs are Moore-decoded from state and registers. There are no combinational paths from the inputs to the outputs.

## Structure
- The shared CPU package holds:
  - div_state_t enum (IDLE, CALC, FIX, DONE);
  - the DIV_WIDTH=32 constant, used as the WIDTH default.
- One sub-module is natural: div_step. It is a purely combinational single shift/trial-subtract step: inputs rem, quo and divisor magnitude; outputs next rem and next quo. div_unit instantiates it once and iterates it.
- The sign-fix negations stay inline in div_unit.

## Test plan
- Positive operands: DivA=100, DivB=7, start pulse → DivBusy high for 33 cycles, then DivDone for exactly 1 cycle with Lo=14, Hi=2, DivZero=0.
- Mixed signs:
  - -7/2 → Lo=0xFFFFFFFD, Hi=0xFFFFFFFF;
  - 7/-2 → Lo=0xFFFFFFFD, Hi=1;
  - -7/-2 → Lo=3, Hi=0xFFFFFFFF.
- Divide by zero: DivA=5, DivB=0, with prior Lo=14 and Hi=2 → DivDone in the next cycle, DivZero=1, Hi/Lo stay 2/14. The next valid start clears DivZero.
- Overflow: 0x80000000 / 0xFFFFFFFF → Lo=0x80000000, Hi=0, DivZero=0.
- Busy protection: start 100/7, then pulse DivControl with 9/3 and change DivA/DivB during CALC → result is still Lo=14, Hi=2 at cycle 34, and only one DivDone pulse.
- Mid-operation reset: assert Reset at cycle 10 of CALC → Hi=Lo=0 and all flags 0 immediately. After release, a new 9/3 start gives Lo=3, Hi=0 with full latency.
